// File: rtl/lfsr_pkg.sv
// Shared types and constants for the lfsr transmit sequencer.
// Holds data widths, the sequencer FSM state type and the default start length.
package lfsr_pkg;

  localparam int BYTE_W           = 8;
  localparam int KEY_W            = 8;
  localparam int TAP_W            = 3;
  localparam int START_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/lfsr_tx_fifo.sv
// Small synchronous byte FIFO feeding the lfsr transmit sequencer.
// Pushes into a full FIFO are dropped; flush empties it and beats a same-cycle push.
// The head is read combinationally so the sequencer can register it straight into in_byte.
module lfsr_tx_fifo
  import lfsr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  input  logic              flush,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full_q && !flush;
  assign pop_ok  = pop && !empty_q && !flush;

  // Next pointers and occupancy; flags are derived from the next count so they stay registered.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
    end
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/lfsr_tx_seq.sv
// Upstream sequencer for the lfsr encryptor: buffers host bytes, then on go
// latches key/tap, holds start for START_CYCLES cycles and streams bytes on in_byte/in_en.
// Abort pulses stop and flushes the buffer. All outputs are registered.
// Optional feature macro: LFSR_TX_OVF_EN adds a sticky ovf output for dropped writes.
module lfsr_tx_seq
  import lfsr_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int START_CYCLES = START_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] wr_byte,
  input  logic              wr_en,
  output logic              full,
  output logic [AW:0]       count,
  input  logic [KEY_W-1:0]  cfg_key,
  input  logic [TAP_W-1:0]  cfg_tap,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [KEY_W-1:0]  key,
  output logic [TAP_W-1:0]  tap,
  output logic              start,
  output logic              stop,
  output logic [BYTE_W-1:0] in_byte,
  output logic              in_en
`ifdef LFSR_TX_OVF_EN
  ,output logic             ovf
`endif
);

  localparam int CW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic [BYTE_W-1:0] in_byte_q, in_byte_d;
  logic              in_en_q, in_en_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              fifo_pop;
  logic              fifo_flush;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  lfsr_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .din   (wr_byte),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Next state and next registered outputs; the last start cycle already pops byte 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    tap_d      = tap_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    in_byte_d  = '0;
    in_en_d    = 1'b0;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          if (!fifo_empty) begin
            state_d = START;
            key_d   = cfg_key;
            tap_d   = cfg_tap;
            start_d = 1'b1;
            cnt_d   = CW'(START_CYCLES - 1);
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      START: begin
        if (abort) begin
          stop_d     = 1'b1;
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d   = cnt_q - CW'(1);
          start_d = 1'b1;
        end else begin
          state_d = SEND;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            in_en_d   = 1'b1;
            in_byte_d = fifo_dout;
          end
        end
      end
      SEND: begin
        if (abort) begin
          stop_d     = 1'b1;
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          in_en_d   = 1'b1;
          in_byte_d = fifo_dout;
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter, key/tap latches and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      tap_q     <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      in_byte_q <= '0;
      in_en_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      tap_q     <= tap_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      in_byte_q <= in_byte_d;
      in_en_q   <= in_en_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign full    = fifo_full;
  assign busy    = busy_q;
  assign done    = done_q;
  assign key     = key_q;
  assign tap     = tap_q;
  assign start   = start_q;
  assign stop    = stop_q;
  assign in_byte = in_byte_q;
  assign in_en   = in_en_q;

`ifdef LFSR_TX_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a dropped write sets it, an accepted go clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && fifo_full)        ovf_d = 1'b1;
    else if (state_q == IDLE && go) ovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_lfsr_tx_seq.sv
// Directed self-checking bench for lfsr_tx_seq (default parameters, START_CYCLES=2).
module tb_lfsr_tx_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_byte = '0;
  logic       wr_en = 1'b0;
  logic       full;
  logic [3:0] count;
  logic [7:0] cfg_key = '0;
  logic [2:0] cfg_tap = '0;
  logic       go = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] key;
  logic [2:0] tap;
  logic       start;
  logic       stop;
  logic [7:0] in_byte;
  logic       in_en;
`ifdef LFSR_TX_OVF_EN
  logic       ovf;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lfsr_tx_seq dut (
    .clk     (clk),
    .reset   (reset),
    .wr_byte (wr_byte),
    .wr_en   (wr_en),
    .full    (full),
    .count   (count),
    .cfg_key (cfg_key),
    .cfg_tap (cfg_tap),
    .go      (go),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .key     (key),
    .tap     (tap),
    .start   (start),
    .stop    (stop),
    .in_byte (in_byte),
    .in_en   (in_en)
`ifdef LFSR_TX_OVF_EN
    ,.ovf    (ovf)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_byte = first + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_go(input logic [7:0] k, input logic [2:0] t);
    cfg_key = k;
    cfg_tap = t;
    go      = 1'b1;
    tick();
    go      = 1'b0;
  endtask

  task automatic test_reset;
    logic [28:0] obs;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    obs = {start, stop, in_en, in_byte, done, busy, key, tap, full, count};
    total_cnt++;
    if (obs !== 29'd0) $display("FAIL reset_outputs got=%h exp=%h", obs, 29'd0);
    else pass_cnt++;
    $display("txn reset: outputs=%h", obs);
`ifdef LFSR_TX_OVF_EN
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_fill_overflow;
    push_bytes(8'h61, 8);
    total_cnt++;
    if ({full, count} !== {1'b1, 4'd8}) $display("FAIL fill got full=%b count=%0d exp full=1 count=8", full, count);
    else pass_cnt++;
    wr_en   = 1'b1;
    wr_byte = 8'h69;
    tick();
    wr_en   = 1'b0;
    total_cnt++;
    if ({full, count} !== {1'b1, 4'd8}) $display("FAIL overflow_drop got full=%b count=%0d exp full=1 count=8", full, count);
    else pass_cnt++;
`ifdef LFSR_TX_OVF_EN
    total_cnt++;
    if (ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", ovf);
    else pass_cnt++;
`endif
    $display("txn overflow: count=%0d full=%b", count, full);
  endtask

  task automatic test_stream;
    logic [12:0] obs, exp;
    logic [7:0]  eb;
    pulse_go(8'b10010101, 3'd4);
`ifdef LFSR_TX_OVF_EN
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf);
    else pass_cnt++;
`endif
    for (int c = 0; c < 12; c++) begin
      eb = 8'h61 + 8'(c - 2);
      if (c < 2)        exp = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      else if (c < 10)  exp = {1'b0, 1'b0, 1'b1, eb, 1'b0, 1'b1};
      else if (c == 10) exp = {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      else              exp = '0;
      obs = {start, stop, in_en, in_byte, done, busy};
      total_cnt++;
      if (obs !== exp) $display("FAIL stream c=%0d got=%h exp=%h", c, obs, exp);
      else pass_cnt++;
      $display("txn stream c=%0d start=%b in_en=%b in_byte=%h done=%b", c, start, in_en, in_byte, done);
      tick();
    end
    total_cnt++;
    if ({key, tap} !== {8'b10010101, 3'd4}) $display("FAIL stream_keytap got key=%h tap=%0d exp key=95 tap=4", key, tap);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    logic [8:0] obs;
    push_bytes(8'h61, 8);
    pulse_go(8'h3C, 3'd1);
    for (int c = 0; c < 5; c++) tick();
    total_cnt++;
    if ({in_en, in_byte} !== {1'b1, 8'h64}) $display("FAIL abort_pre got in_en=%b in_byte=%h exp in_en=1 in_byte=64", in_en, in_byte);
    else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    obs = {stop, start, in_en, done, busy, count};
    total_cnt++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) $display("FAIL abort_stop got=%h exp=%h", obs, 9'h100);
    else pass_cnt++;
    $display("txn abort: stop=%b busy=%b count=%0d", stop, busy, count);
    tick();
    total_cnt++;
    if ({stop, done, busy, start, in_en} !== 5'd0) $display("FAIL abort_after got=%b exp=00000", {stop, done, busy, start, in_en});
    else pass_cnt++;
  endtask

  task automatic test_empty_go;
    pulse_go(8'h00, 3'd0);
    total_cnt++;
    if ({start, in_en, done, busy} !== 4'b0011) $display("FAIL empty_go got=%b exp=0011", {start, in_en, done, busy});
    else pass_cnt++;
    $display("txn empty_go: done=%b busy=%b", done, busy);
    tick();
    total_cnt++;
    if ({start, in_en, done, busy} !== 4'b0000) $display("FAIL empty_go_end got=%b exp=0000", {start, in_en, done, busy});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [12:0] obs, exp;
    logic [7:0]  eb;
    push_bytes(8'h41, 2);
    pulse_go(8'h5A, 3'd2);
    for (int c = 0; c < 12; c++) begin
      eb = (c == 2) ? 8'h41 : (c == 3) ? 8'h42 : 8'h70;
      if (c < 2)        exp = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      else if (c < 10)  exp = {1'b0, 1'b0, 1'b1, eb, 1'b0, 1'b1};
      else if (c == 10) exp = {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      else              exp = '0;
      obs = {start, stop, in_en, in_byte, done, busy};
      total_cnt++;
      if (obs !== exp) $display("FAIL b2b c=%0d got=%h exp=%h", c, obs, exp);
      else pass_cnt++;
      $display("txn b2b c=%0d in_en=%b in_byte=%h done=%b", c, in_en, in_byte, done);
      wr_en   = (c >= 2 && c <= 7);
      wr_byte = 8'h70;
      go      = (c == 4);
      cfg_key = 8'hFF;
      tick();
    end
    wr_en = 1'b0;
    go    = 1'b0;
    total_cnt++;
    if ({key, tap} !== {8'h5A, 3'd2}) $display("FAIL busy_go_ignored got key=%h tap=%0d exp key=5a tap=2", key, tap);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [28:0] obs;
    push_bytes(8'h11, 4);
    pulse_go(8'h22, 3'd3);
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    obs = {start, stop, in_en, in_byte, done, busy, key, tap, full, count};
    total_cnt++;
    if (obs !== 29'd0) $display("FAIL reset_mid got=%h exp=%h", obs, 29'd0);
    else pass_cnt++;
    $display("txn reset_mid: outputs=%h", obs);
    push_bytes(8'h55, 1);
    pulse_go(8'b01110110, 3'd6);
    total_cnt++;
    if ({start, in_en, key, tap} !== {1'b1, 1'b0, 8'b01110110, 3'd6}) $display("FAIL fresh_c0 got=%h exp=%h", {start, in_en, key, tap}, {1'b1, 1'b0, 8'b01110110, 3'd6});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({start, in_en} !== 2'b10) $display("FAIL fresh_c1 got=%b exp=10", {start, in_en});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({start, in_en, in_byte} !== {1'b0, 1'b1, 8'h55}) $display("FAIL fresh_c2 got=%h exp=%h", {start, in_en, in_byte}, {1'b0, 1'b1, 8'h55});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, in_en} !== 2'b10) $display("FAIL fresh_done got=%b exp=10", {done, in_en});
    else pass_cnt++;
    $display("txn fresh: done=%b", done);
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_stream();
    test_abort();
    test_empty_go();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
